register_bank_8088: RTL and testbench
=====================================

REGISTER_BANK_8088 -- requirements
Module: register_bank_8088

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 en_write  input  1  write enable, sampled on rising clk.
REQ-005 reg_write  input  3  write register index: 0 AX, 1 BX, 2 CX, 3 DX, 4 SP, 5 BP, 6 SI, 7 DI.
REQ-006 write_data  input  16  write data.
REQ-007 reg_read1  input  3  read port 1 register index (same encoding as REQ-005).
REQ-008 reg_read2  input  3  read port 2 register index (same encoding as REQ-005).
REQ-009 size  input  1  write width: 1 = 16-bit word, 0 = 8-bit byte.
REQ-010 select_high_low  input  1  byte-write lane when size=0: 0 = low byte [7:0], 1 = high byte [15:8].
REQ-011 read_data1  output  16  full 16-bit contents of register reg_read1.
REQ-012 read_data2  output  16  full 16-bit contents of register reg_read2.

Function
REQ-013 The block SHALL hold eight 16-bit registers indexed 0-7 per REQ-005.
REQ-014 Word write: on rising clk with en_write=1 and size=1, register reg_write SHALL load write_data[15:0].
REQ-015 Byte write, low lane: with en_write=1, size=0 and select_high_low=0, register reg_write[7:0] SHALL load write_data[7:0]; bits [15:8] SHALL be unchanged.
REQ-016 Byte write, high lane: with en_write=1, size=0 and select_high_low=1, register reg_write[15:8] SHALL load write_data[7:0]; bits [7:0] SHALL be unchanged.
REQ-017 Byte writes SHALL apply only to indices 0-3 (AX, BX, CX, DX); a byte write to indices 4-7 SHALL be ignored, leaving the register unchanged.
REQ-018 With en_write=0, no register SHALL change.
REQ-019 Reads SHALL be combinational and zero-latency; they SHALL always return the full 16 bits, independent of size and select_high_low.
REQ-020 Both read ports SHALL be independent; both may address the same register at the same time.
REQ-021 Read during write (without REQ-027): a read of the register being written SHALL return the old value until the clock edge, and the new value afterward.
REQ-022 Only one register SHALL be written per cycle; all other registers SHALL hold their values.

Reset
REQ-023 While reset=1 at a rising clk, all eight registers SHALL clear to 16'h0000.
REQ-024 Reset SHALL take priority over any simultaneous write.
REQ-025 After reset, read_data1 and read_data2 SHALL be 16'h0000 for any index.
REQ-026 Reset asserted in the middle of a write sequence SHALL discard that cycle's write.

Configuration
REQ-027 Macro REGBANK_WRITE_BYPASS_EN:
- When defined: when en_write=1, reset=0, and a read index equals reg_write, that read port SHALL return the post-write value (the merged byte for byte writes) combinationally in the same cycle.
- When undefined: REQ-021 applies.
- Bypass SHALL follow REQ-017: a byte write to indices 4-7 is not forwarded.

Verification
REQ-028 Reset, then a word write of 16'hABCD to AX; read1=0 -> read_data1=16'hABCD after the edge.
REQ-029 Byte write 16'h00EF to BX low lane, then byte write 16'h0012 to BX high lane; read1=1 -> read_data1=16'h12EF.
REQ-030 Word writes CX=16'h3456 and DX=16'h789A; read1=2, read2=3 -> 16'h3456 and 16'h789A at the same time.
REQ-031 Word writes SP=FFFC, BP=AABB, SI=CCDD, DI=EEFF; reads (4,7) then (5,6) -> (FFFC,EEFF) then (AABB,CCDD); a byte write of 16'h0055 to SP -> SP stays 16'hFFFC.
REQ-032 With AX=ABCD, assert reset together with en_write=1 and data 16'h1111 -> AX=16'h0000; with en_write=0, write_data changes -> no register changes.
REQ-033 Read during write of AX=16'h5A5A, read1=0: without the macro, read_data1 shows the old value before the edge; with REGBANK_WRITE_BYPASS_EN, read_data1 shows 16'h5A5A in the same cycle.

Source files
------------

// File: rtl/register_bank_8088.sv
// 8088-style register bank: eight 16-bit registers, word or byte-lane writes, two async read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGBANK_WRITE_BYPASS_EN.
module register_bank_8088 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_write,
  input  logic [2:0]  reg_write,
  input  logic [15:0] write_data,
  input  logic [2:0]  reg_read1,
  input  logic [2:0]  reg_read2,
  input  logic        size,
  input  logic        select_high_low,
  output logic [15:0] read_data1,
  output logic [15:0] read_data2
);

  logic [15:0] r_regs [8];
  logic [15:0] w_cur;
  logic [15:0] w_merged;
  logic        w_do_write;

  assign w_cur = r_regs[reg_write];

  // Byte writes merge the new byte into the untouched lane of the current value.
  always_comb begin
    w_merged = write_data;
    if (!size) begin
      if (select_high_low) w_merged = {write_data[7:0], w_cur[7:0]};
      else                 w_merged = {w_cur[15:8], write_data[7:0]};
    end
  end

  // Only AX..DX (index bit 2 clear) have addressable byte halves.
  assign w_do_write = en_write && (size || !reg_write[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_do_write) begin
      r_regs[reg_write] <= w_merged;
    end
  end

`ifdef REGBANK_WRITE_BYPASS_EN
  logic w_fwd;
  assign w_fwd      = w_do_write && !reset;
  assign read_data1 = (w_fwd && (reg_read1 == reg_write)) ? w_merged : r_regs[reg_read1];
  assign read_data2 = (w_fwd && (reg_read2 == reg_write)) ? w_merged : r_regs[reg_read2];
`else
  assign read_data1 = r_regs[reg_read1];
  assign read_data2 = r_regs[reg_read2];
`endif

endmodule

// File: tb/tb_register_bank_8088.sv
// Self-checking bench for register_bank_8088: directed scenarios then random traffic vs a reference model.
module tb_register_bank_8088;
  logic        clk;
  logic        reset;
  logic        en_write;
  logic [2:0]  reg_write;
  logic [15:0] write_data;
  logic [2:0]  reg_read1;
  logic [2:0]  reg_read2;
  logic        size;
  logic        select_high_low;
  logic [15:0] read_data1;
  logic [15:0] read_data2;

  int n_cmp;
  int n_bad;
  int model [8];

  register_bank_8088 dut (
    .clk(clk), .reset(reset), .en_write(en_write), .reg_write(reg_write),
    .write_data(write_data), .reg_read1(reg_read1), .reg_read2(reg_read2),
    .size(size), .select_high_low(select_high_low),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a register holds after the given write is applied to old contents.
  function automatic int apply_write(int old, int data, int sz, int hl, int idx);
    if (sz == 1) return data & 32'hFFFF;
    if (idx >= 4) return old;
    if (hl == 1) return (old & 32'h00FF) | ((data & 32'hFF) << 8);
    return (old & 32'hFF00) | (data & 32'hFF);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check reads before the edge, advance the model at the edge.
  task automatic cycle(input int we, input int rst, input int idx, input int data,
                       input int sz, input int hl, input int r1, input int r2);
    int exp1, exp2, post;
    en_write = we[0]; reset = rst[0]; reg_write = idx[2:0]; write_data = data[15:0];
    size = sz[0]; select_high_low = hl[0]; reg_read1 = r1[2:0]; reg_read2 = r2[2:0];
    #1;
    post = apply_write(model[idx], data, sz, hl, idx);
    exp1 = model[r1];
    exp2 = model[r2];
`ifdef REGBANK_WRITE_BYPASS_EN
    if (we == 1 && rst == 0 && r1 == idx) exp1 = post;
    if (we == 1 && rst == 0 && r2 == idx) exp2 = post;
`endif
    check("rd1_pre", read_data1, exp1[15:0]);
    check("rd2_pre", read_data2, exp2[15:0]);
    @(posedge clk);
    if (rst == 1) begin
      for (int i = 0; i < 8; i++) model[i] = 0;
    end else if (we == 1) begin
      model[idx] = post;
    end
    @(negedge clk);
    en_write = 1'b0; reset = 1'b0;
    $display("cycle we=%0d rst=%0d idx=%0d data=%04h sz=%0d hl=%0d rd=(%0d,%0d) -> %04h %04h",
             we, rst, idx, data & 32'hFFFF, sz, hl, r1, r2, read_data1, read_data2);
  endtask

  task automatic peek(input string tag, input int r1, input int r2);
    en_write = 1'b0;
    reg_read1 = r1[2:0];
    reg_read2 = r2[2:0];
    #1;
    check(tag, read_data1, model[r1][15:0]);
    check(tag, read_data2, model[r2][15:0]);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 8; i++) model[i] = 0;
    reset = 1'b1; en_write = 1'b0; reg_write = '0; write_data = '0;
    reg_read1 = '0; reg_read2 = '0; size = 1'b1; select_high_low = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) peek("reset_zero", i, 7 - i);

    cycle(1, 0, 0, 16'hABCD, 1, 0, 0, 0);
    peek("ax_word", 0, 0);
    cycle(1, 0, 1, 16'h00EF, 0, 0, 1, 1);
    cycle(1, 0, 1, 16'h0012, 0, 1, 1, 0);
    peek("bx_bytes", 1, 1);
    check("bx_const", read_data1, 16'h12EF);
    cycle(1, 0, 2, 16'h3456, 1, 0, 2, 3);
    cycle(1, 0, 3, 16'h789A, 1, 0, 2, 3);
    peek("cx_dx", 2, 3);
    cycle(1, 0, 4, 16'hFFFC, 1, 0, 4, 7);
    cycle(1, 0, 5, 16'hAABB, 1, 0, 5, 6);
    cycle(1, 0, 6, 16'hCCDD, 1, 0, 4, 6);
    cycle(1, 0, 7, 16'hEEFF, 1, 0, 7, 5);
    peek("sp_di", 4, 7);
    peek("bp_si", 5, 6);
    cycle(1, 0, 4, 16'h0055, 0, 0, 4, 4);
    cycle(1, 0, 4, 16'h0055, 0, 1, 4, 0);
    peek("sp_byte_ign", 4, 4);
    check("sp_const", read_data1, 16'hFFFC);
    cycle(1, 1, 0, 16'h1111, 1, 0, 0, 1);
    peek("rst_prio", 0, 1);
    check("ax_rst_const", read_data1, 16'h0000);
    cycle(1, 0, 0, 16'hABCD, 1, 0, 0, 0);
    cycle(0, 0, 0, 16'h7777, 1, 0, 0, 1);
    cycle(0, 0, 2, 16'h8888, 0, 1, 2, 3);
    for (int i = 0; i < 8; i++) peek("no_we", i, i);
    cycle(1, 0, 0, 16'h5A5A, 1, 0, 0, 0);
    peek("rdw_after", 0, 0);

    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 31) == 0) ? 1 : 0,
            $urandom_range(0, 7), $urandom_range(0, 65535),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 7));
      if ((k % 8) == 0) peek("rand_peek", $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
